bucket_fifo_16x8: RTL and testbench

- Synchronous 16-deep x 8-bit first-word-fall-through FIFO built as a bucket-brigade shift register.
- Every accepted write shifts all stored bytes one slot deeper, and a read pointer selects the oldest byte.
- Used as the small receive/transmit byte buffer between a serial byte engine (UART/USB byte path) and its consumer.
- Status is reported as data_present, half_full and full.

---
 rtl/bucket_fifo_16x8_if.sv | 34 +++
 rtl/bucket_fifo_16x8.sv | 81 ++++++++
 tb/tb_bucket_fifo_16x8.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bucket_fifo_16x8_if.sv
// Byte-path interface for bucket_fifo_16x8.
// The producer/consumer side uses the master modport, the FIFO uses slave.
// Defining BBFIFO_ERR_FLAGS_EN adds the sticky overflow/underflow flags.
interface bucket_fifo_16x8_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             half_full;
  logic             data_present;
`ifdef BBFIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output data_in, write, read,
    input  data_out, full, half_full, data_present
`ifdef BBFIFO_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  data_in, write, read,
    output data_out, full, half_full, data_present
`ifdef BBFIFO_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/bucket_fifo_16x8.sv
// 16 x 8 first-word-fall-through FIFO built as a bucket-brigade shifter.
// Each accepted write shifts every stored byte one slot deeper; ptr points
// at the oldest byte. Occupancy = data_present ? ptr+1 : 0.
// Optional macro BBFIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module bucket_fifo_16x8 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic               clk,
  input logic               reset,
  bucket_fifo_16x8_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] sr [DEPTH];
  logic [PW-1:0]    ptr;
  logic             present;
  logic             full_int;
  logic             wr_ok;
  logic             rd_ok;

  assign full_int = present && (ptr == PW'(DEPTH - 1));
  // A write while full still goes in if the same cycle pops the oldest byte.
  assign wr_ok    = bus.write && (!full_int || bus.read);
  assign rd_ok    = bus.read && present;

  assign bus.full         = full_int;
  assign bus.half_full    = present && (ptr >= PW'(DEPTH / 2 - 1));
  assign bus.data_present = present;

  // Storage shift; no reset since occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      sr[0] <= bus.data_in;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  // Read pointer and presence flag; simultaneous write+read leaves both as-is
  // because the shift moves the next-oldest byte into the slot ptr selects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= '0;
      present <= 1'b0;
    end else if (wr_ok && !rd_ok) begin
      if (present) ptr <= ptr + 1'b1;
      else         present <= 1'b1;
    end else if (rd_ok && !wr_ok) begin
      if (ptr != '0) ptr <= ptr - 1'b1;
      else           present <= 1'b0;
    end
  end

  // Oldest byte, forced to zero when empty so reset clears it immediately.
  always_comb begin
    bus.data_out = '0;
    if (present) bus.data_out = sr[ptr];
  end

`ifdef BBFIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.write && !wr_ok)   ovf_q <= 1'b1;
      if (bus.read && !present)  unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_bucket_fifo_16x8.sv
// Directed bench for bucket_fifo_16x8. Stimulus pushes the byte each read is
// expected to pop; a negedge monitor pops and compares on every accepted read.
module tb_bucket_fifo_16x8;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [7:0] exp_q[$];

  bucket_fifo_16x8_if #(.WIDTH(8)) bus ();

  bucket_fifo_16x8 #(.WIDTH(8), .DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Called at posedge+1; drives one cycle of inputs and returns at next posedge+1.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    bus.write   = w;
    bus.read    = r;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.data_in = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: every accepted read must pop the byte the stimulus predicted.
  always @(negedge clk) begin
    if (reset && bus.read && bus.data_present) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected none at %0t", bus.data_out, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t", bus.data_out, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b0;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    // Reset / idle state
    chk("rst_present", {7'd0, bus.data_present}, 8'd0);
    chk("rst_half",    {7'd0, bus.half_full},    8'd0);
    chk("rst_full",    {7'd0, bus.full},         8'd0);
    chk("rst_dout",    bus.data_out,             8'h00);
`ifdef BBFIFO_ERR_FLAGS_EN
    chk("rst_ovf", {7'd0, bus.overflow},  8'd0);
    chk("rst_unf", {7'd0, bus.underflow}, 8'd0);
`endif

    // Fill with 0x01..0x10, one write every other cycle
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 1'b0, 8'(k));
      if (k == 1) begin
        chk("w1_present", {7'd0, bus.data_present}, 8'd1);
        chk("w1_dout",    bus.data_out,             8'h01);
      end
      if (k == 7)  chk("w7_half",  {7'd0, bus.half_full}, 8'd0);
      if (k == 8)  chk("w8_half",  {7'd0, bus.half_full}, 8'd1);
      if (k == 15) chk("w15_full", {7'd0, bus.full},      8'd0);
      if (k == 16) chk("w16_full", {7'd0, bus.full},      8'd1);
      idle(1);
    end

    // Rejected write while full
    cyc(1'b1, 1'b0, 8'h11);
    chk("rej_dout", bus.data_out,        8'h01);
    chk("rej_full", {7'd0, bus.full},    8'd1);
`ifdef BBFIFO_ERR_FLAGS_EN
    chk("rej_ovf",  {7'd0, bus.overflow}, 8'd1);
`endif

    // Drain with read held for 20 cycles; 0x11 must not appear
    for (int k = 1; k <= 16; k++) exp_q.push_back(8'(k));
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b1, 8'h00);
      if (k == 1)  chk("r1_full",   {7'd0, bus.full},         8'd0);
      if (k == 8)  chk("r8_half",   {7'd0, bus.half_full},    8'd1);
      if (k == 9)  chk("r9_half",   {7'd0, bus.half_full},    8'd0);
      if (k == 15) chk("r15_pres",  {7'd0, bus.data_present}, 8'd1);
      if (k == 16) chk("r16_pres",  {7'd0, bus.data_present}, 8'd0);
    end
    chk("drain_dout", bus.data_out, 8'h00);
    chk("drain_q",    8'(exp_q.size()), 8'd0);
`ifdef BBFIFO_ERR_FLAGS_EN
    chk("drain_unf",  {7'd0, bus.underflow}, 8'd1);
`endif

    // 13 entries, then concurrent write+read keeps occupancy at 13
    for (int k = 1; k <= 13; k++) cyc(1'b1, 1'b0, 8'(k));
    chk("f13_half", {7'd0, bus.half_full}, 8'd1);
    chk("f13_dout", bus.data_out,          8'h01);
    for (int k = 1; k <= 17; k++) exp_q.push_back(8'(k));
    for (int k = 14; k <= 17; k++) begin
      cyc(1'b1, 1'b1, 8'(k));
      chk("wr_rd_full", {7'd0, bus.full},      8'd0);
      chk("wr_rd_half", {7'd0, bus.half_full}, 8'd1);
    end
    chk("wr_rd_dout", bus.data_out, 8'h05);
    for (int k = 0; k < 13; k++) cyc(1'b0, 1'b1, 8'h00);
    chk("wr_rd_empty", {7'd0, bus.data_present}, 8'd0);
    chk("wr_rd_q",     8'(exp_q.size()),         8'd0);

    // Write+read on a full FIFO replaces the oldest byte
    for (int k = 1; k <= 16; k++) cyc(1'b1, 1'b0, 8'(k));
    exp_q.push_back(8'h01);
    cyc(1'b1, 1'b1, 8'h55);
    chk("fwr_full", {7'd0, bus.full}, 8'd1);
    chk("fwr_dout", bus.data_out,     8'h02);
    for (int k = 2; k <= 16; k++) exp_q.push_back(8'(k));
    exp_q.push_back(8'h55);
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1, 8'h00);
    chk("fwr_empty", {7'd0, bus.data_present}, 8'd0);
    chk("fwr_q",     8'(exp_q.size()),         8'd0);

    // Asynchronous reset with the FIFO half full
    for (int k = 1; k <= 8; k++) cyc(1'b1, 1'b0, 8'(8'h20 + k));
    chk("pre_rst_half", {7'd0, bus.half_full}, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_present", {7'd0, bus.data_present}, 8'd0);
    chk("arst_half",    {7'd0, bus.half_full},    8'd0);
    chk("arst_dout",    bus.data_out,             8'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    cyc(1'b1, 1'b0, 8'hA5);
    chk("post_present", {7'd0, bus.data_present}, 8'd1);
    chk("post_dout",    bus.data_out,             8'hA5);
    chk("post_half",    {7'd0, bus.half_full},    8'd0);
    exp_q.push_back(8'hA5);
    cyc(1'b0, 1'b1, 8'h00);
    chk("post_empty", {7'd0, bus.data_present}, 8'd0);
    chk("final_q",    8'(exp_q.size()),         8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
